wb_irq_ctrl: RTL and testbench
==============================

# wb_irq_ctrl

Wishbone-slave interrupt controller between the board-level interrupt sources (pushbuttons, switches, UART/timer events from the peripheral block) and the picorv32 `irq`/`eoi` port pair. It synchronises up to 32 raw sources and latches each as edge- or level-triggered pending bits. It exposes enable/mode/pending registers to software over the peripheral Wishbone bus. It clears edge-triggered pending bits automatically when the core signals end-of-interrupt.

## Interface
Parameters:
- `N_SRC`, default 8: number of sources, 1..32.
- `IRQ_BASE`, default 3: bit of `o_irq` driven by source 0; requires `IRQ_BASE+N_SRC <= 32`. Bits 0..2 are reserved for core-internal IRQs.
- `SYNC_STAGES`, default 2: synchroniser depth on `i_src`, minimum 2.

Ports (clock and reset first):
- `i_clk`, in, 1: system clock.
- `in_rst`, in, 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `i_src`, in, N_SRC: raw interrupt sources, asynchronous to `i_clk`.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we`, in, 1 each: Wishbone cycle, strobe and write enable.
- `i_wb_addr`, in, 32: byte address. Only `[4:2]` is decoded.
- `i_wb_data`, in, 32: write data.
- `i_wb_sel`, in, 4: byte-lane enables.
- `o_wb_stall`, out, 1: held at 0.
- `o_wb_ack`, out, 1: registered acknowledge.
- `o_wb_data`, out, 32: registered read data.
- `o_irq`, out, 32: interrupt requests to the core.
- `i_eoi`, in, 32: end-of-interrupt vector from the core.

## Operation
Registers, selected by `i_wb_addr[4:2]`; bits at and above `N_SRC` read 0 and ignore writes:
- 0 PENDING: read; write-1-to-clear for edge-mode bits only.
- 1 ENABLE: read/write, byte-lane masked by `i_wb_sel`.
- 2 MODE: read/write, byte-lane masked; 1 = rising-edge, 0 = level-high.
- 3 STATUS: read-only, PENDING & ENABLE.
- 4 FORCE: write-only, reads 0; writing 1 sets PENDING[k] for edge-mode bits.
- 5..7: read 0, writes ignored, still acknowledged.

Per-source behaviour:
- Level mode: PENDING[k] <= synchronised `src[k]` every cycle. W1C and FORCE have no effect.
- Edge mode: PENDING[k] is set when `sync[k] & ~prev[k]`, where `prev[k]` always tracks `sync[k]`. It is cleared by a W1C write, or by a falling edge of `i_eoi[IRQ_BASE+k]` (sampled 1 then 0).
- Simultaneous set and clear in the same cycle (edge/FORCE against W1C/EOI): set wins.
- A MODE write that changes bit k from 0 to 1 clears PENDING[k] in that same cycle, unless an edge occurs in that cycle.
- `o_irq[IRQ_BASE+k]` <= PENDING[k] & ENABLE[k], registered. All other `o_irq` bits are constantly 0.

## Timing
- Reset values are 0 for: PENDING, ENABLE, MODE, synchroniser flops, `prev`, `eoi` history, `o_irq`, `o_wb_ack`, `o_wb_data`. `o_wb_stall` is constant 0.
- Wishbone access: `o_wb_ack` is high exactly one cycle, on the clock edge after `i_wb_cyc & i_wb_stb` is sampled. `o_wb_data` is valid in the same cycle as the ack and 0 otherwise.
- Back-to-back strobes are accepted every cycle. Register writes take effect at the edge that raises the ack.
- Source latency: for a sample first captured high at edge E, PENDING updates at E+SYNC_STAGES and `o_irq` at E+SYNC_STAGES+1. This is 3 edges for the default depth.
- EOI latency: PENDING clears on the edge that samples `i_eoi` low after high. `o_irq` falls one edge later.
- An ENABLE write alters `o_irq` on the following edge.
- Reset asserted mid-transaction: ack is dropped immediately (asynchronous) and the transaction is lost. The master must retry.

## Structure
- Package `irq_ctrl_pkg`: register index constants (`IRQ_REG_PENDING`=0 … `IRQ_REG_FORCE`=4) and the `IRQ_RESERVED`=3 constant.
- Sub-module `irq_src_sync`: a `SYNC_STAGES` synchroniser plus `prev` register for one bit, outputting `level` and `rise`. Instantiated N_SRC times via generate.
- Top level holds the register file, Wishbone decode and EOI edge detection.

## Test plan
- Reset, then read all 8 offsets -> each returns 0x00000000 with ack exactly one cycle after strobe; `o_irq` is 0.
- MODE=0x01, ENABLE=0x01; pulse `i_src[0]` high for 5 cycles -> PENDING=0x01 and `o_irq`=0x00000008 three edges after capture. Pulse `i_eoi[3]` 1 then 0 -> PENDING=0 and `o_irq`=0 one edge later.
- MODE=0, ENABLE=0x80; hold `i_src[7]`=1 -> `o_irq[10]`=1. Write PENDING=0x80 -> still 1. Drop `i_src[7]` -> `o_irq[10]`=0 after 3 edges.
- Edge mode bit 2: inject a rising edge in the same cycle as a W1C of 0x04 -> PENDING[2] remains 1.
- FORCE=0xFF with MODE=0x0F, ENABLE=0xFF -> PENDING=0x0F, STATUS=0x0F, `o_irq`=0x00000078.
- Write ENABLE=0xFFFF_FFFF with sel=4'b0001 and N_SRC=8 -> read ENABLE returns 0x000000FF. A write to offset 6 is acked and has no effect.

Source files
------------

// File: rtl/wb_irq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// irq_ctrl_pkg
//
// Shared definitions for the Wishbone interrupt controller:
//   - register index constants, decoded from i_wb_addr[4:2]
//   - the number of o_irq bits owned by the core itself
//   - a helper that expands a Wishbone byte-select into a 32-bit bit mask
// ----------------------------------------------------------------------------
package irq_ctrl_pkg;

    // Register indices (word offsets within the 8-word window)
    localparam logic [2:0] IRQ_REG_PENDING = 3'd0;
    localparam logic [2:0] IRQ_REG_ENABLE  = 3'd1;
    localparam logic [2:0] IRQ_REG_MODE    = 3'd2;
    localparam logic [2:0] IRQ_REG_STATUS  = 3'd3;
    localparam logic [2:0] IRQ_REG_FORCE   = 3'd4;

    // o_irq bits 0..IRQ_RESERVED-1 belong to core-internal interrupts
    localparam int IRQ_RESERVED = 3;

    // Expand the four byte-lane enables into a per-bit write mask
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_irq_ctrl_src_sync.sv
// ----------------------------------------------------------------------------
// irq_src_sync
//
// Single-bit synchroniser for one asynchronous interrupt source, followed by a
// history flop used for rising-edge detection.
//
// Ports:
//   i_clk   in   system clock
//   in_rst  in   asynchronous active-low reset
//   i_src   in   raw source, asynchronous to i_clk
//   o_level out  synchronised source (last synchroniser stage)
//   o_rise  out  one-cycle pulse when the synchronised source goes 0 -> 1
// ----------------------------------------------------------------------------
module irq_src_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic in_rst,
    input  logic i_src,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            // Stage 0 captures the raw input; the last stage is the safe copy
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_src};
            // prev always follows the synchronised value, regardless of mode
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign o_level = sync_reg[SYNC_STAGES-1];
    assign o_rise  = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/wb_irq_ctrl.sv
// ----------------------------------------------------------------------------
// wb_irq_ctrl
//
// Wishbone-slave interrupt controller feeding the picorv32 irq/eoi pair.
// Each source is synchronised, then latched into PENDING either as a level
// (follows the source) or as a rising edge (sticky until cleared by software
// W1C or by a falling edge on the matching eoi bit). o_irq is the registered
// PENDING & ENABLE, placed at bit IRQ_BASE upward.
//
// Registers (i_wb_addr[4:2]):
//   0 PENDING  R, W1C on edge-mode bits
//   1 ENABLE   R/W, byte-lane masked
//   2 MODE     R/W, byte-lane masked, 1 = rising edge, 0 = level high
//   3 STATUS   R, PENDING & ENABLE
//   4 FORCE    W, sets PENDING on edge-mode bits, reads 0
//   5..7       read 0, writes ignored
//
// Ports:
//   i_clk, in_rst              clock, asynchronous active-low reset
//   i_src[N_SRC]               raw interrupt sources
//   i_wb_cyc/stb/we/addr/data/sel  Wishbone slave request
//   o_wb_stall/ack/data        Wishbone slave response (stall tied low)
//   o_irq[32]                  interrupt requests to the core
//   i_eoi[32]                  end-of-interrupt vector from the core
// ----------------------------------------------------------------------------
module wb_irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC       = 8,
    parameter int IRQ_BASE    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              in_rst,
    input  logic [N_SRC-1:0]  i_src,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_addr,
    input  logic [31:0]       i_wb_data,
    input  logic [3:0]        i_wb_sel,
    output logic              o_wb_stall,
    output logic              o_wb_ack,
    output logic [31:0]       o_wb_data,
    output logic [31:0]       o_irq,
    input  logic [31:0]       i_eoi
);

    // ------------------------------------------------------------------
    // Source synchronisers
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] src_level;
    logic [N_SRC-1:0] src_rise;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_sync
            irq_src_sync #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .i_clk   (i_clk),
                .in_rst  (in_rst),
                .i_src   (i_src[gi]),
                .o_level (src_level[gi]),
                .o_rise  (src_rise[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] pending_reg, pending_next;
    logic [N_SRC-1:0] enable_reg,  enable_next;
    logic [N_SRC-1:0] mode_reg,    mode_next;
    logic [N_SRC-1:0] eoi_prev_reg;
    logic [31:0]      irq_reg,     irq_next;
    logic             ack_reg;
    logic [31:0]      rd_data_reg, rd_data_next;

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic             wb_req;
    logic             wb_wr;
    logic [2:0]       reg_idx;
    logic [31:0]      sel_mask_full;
    logic [N_SRC-1:0] sel_mask;
    logic [N_SRC-1:0] wr_bits;

    assign wb_req        = i_wb_cyc & i_wb_stb;
    assign wb_wr         = wb_req & i_wb_we;
    assign reg_idx       = i_wb_addr[4:2];
    assign sel_mask_full = lane_mask(i_wb_sel);
    assign sel_mask      = sel_mask_full[N_SRC-1:0];
    assign wr_bits       = i_wb_data[N_SRC-1:0];

    // Per-bit write strobes; bits above N_SRC simply do not exist
    logic [N_SRC-1:0] w1c_bits;
    logic [N_SRC-1:0] force_bits;

    assign w1c_bits   = (wb_wr && reg_idx == IRQ_REG_PENDING) ? wr_bits : '0;
    assign force_bits = (wb_wr && reg_idx == IRQ_REG_FORCE)   ? wr_bits : '0;

    assign enable_next = (wb_wr && reg_idx == IRQ_REG_ENABLE)
                       ? ((enable_reg & ~sel_mask) | (wr_bits & sel_mask))
                       : enable_reg;

    assign mode_next   = (wb_wr && reg_idx == IRQ_REG_MODE)
                       ? ((mode_reg & ~sel_mask) | (wr_bits & sel_mask))
                       : mode_reg;

    // ------------------------------------------------------------------
    // End-of-interrupt: the core pulses eoi high, and the clear happens on
    // the edge that sees it low again.
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] eoi_fall;

    assign eoi_fall = eoi_prev_reg & ~i_eoi[IRQ_BASE +: N_SRC];

    // ------------------------------------------------------------------
    // Pending update
    //
    // Level bits follow the synchronised source. Edge bits are sticky with
    // set taking priority over clear. A bit being switched from level to edge
    // starts clean so a stale level does not masquerade as an edge, unless
    // a genuine edge lands in that very cycle.
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] mode_to_edge;
    logic [N_SRC-1:0] edge_set;
    logic [N_SRC-1:0] edge_clr;

    assign mode_to_edge = mode_next & ~mode_reg;
    assign edge_set     = src_rise | force_bits;
    assign edge_clr     = w1c_bits | eoi_fall;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
            assign pending_next[gi] =
                !mode_reg[gi]     ? (mode_to_edge[gi] ? src_rise[gi] : src_level[gi]) :
                edge_set[gi]      ? 1'b1 :
                edge_clr[gi]      ? 1'b0 :
                                    pending_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read mux and interrupt output
    // ------------------------------------------------------------------
    always_comb begin
        rd_data_next = '0;
        if (wb_req) begin
            case (reg_idx)
                IRQ_REG_PENDING: rd_data_next[N_SRC-1:0] = pending_reg;
                IRQ_REG_ENABLE:  rd_data_next[N_SRC-1:0] = enable_reg;
                IRQ_REG_MODE:    rd_data_next[N_SRC-1:0] = mode_reg;
                IRQ_REG_STATUS:  rd_data_next[N_SRC-1:0] = pending_reg & enable_reg;
                default:         rd_data_next = '0;
            endcase
        end
    end

    always_comb begin
        irq_next = '0;
        irq_next[IRQ_BASE +: N_SRC] = pending_reg & enable_reg;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst) begin
            pending_reg  <= '0;
            enable_reg   <= '0;
            mode_reg     <= '0;
            eoi_prev_reg <= '0;
            irq_reg      <= '0;
            ack_reg      <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            pending_reg  <= pending_next;
            enable_reg   <= enable_next;
            mode_reg     <= mode_next;
            eoi_prev_reg <= i_eoi[IRQ_BASE +: N_SRC];
            irq_reg      <= irq_next;
            ack_reg      <= wb_req;
            rd_data_reg  <= rd_data_next;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_reg;
    assign o_wb_data  = rd_data_reg;
    assign o_irq      = irq_reg;

    // Address bits outside [4:2], data above N_SRC and eoi bits outside the
    // source window are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{i_wb_addr, i_wb_data, i_eoi, sel_mask_full};

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_wb_irq_ctrl
//
// Scenario bench for wb_irq_ctrl with default parameters (8 sources, base 3,
// two synchroniser stages). Inputs are driven 1 time unit after the rising
// edge and outputs are sampled at that same point.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_irq_ctrl;

    localparam int N_SRC    = 8;
    localparam int IRQ_BASE = 3;
    localparam int SYNC     = 2;

    logic              clk;
    logic              in_rst;
    logic [N_SRC-1:0]  src;
    logic              cyc, stb, we;
    logic [31:0]       addr, wdata;
    logic [3:0]        sel;
    logic              stall, ack;
    logic [31:0]       rdata;
    logic [31:0]       irq;
    logic [31:0]       eoi;

    int checks = 0;
    int errors = 0;

    wb_irq_ctrl #(
        .N_SRC       (N_SRC),
        .IRQ_BASE    (IRQ_BASE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .i_clk      (clk),
        .in_rst     (in_rst),
        .i_src      (src),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .i_wb_sel   (sel),
        .o_wb_stall (stall),
        .o_wb_ack   (ack),
        .o_wb_data  (rdata),
        .o_irq      (irq),
        .i_eoi      (eoi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One isolated bus cycle: a1 is ack one edge after the strobe, a2 one
    // edge later (should have dropped again).
    task automatic wb_access(input logic w, input int off, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd,
                             output logic a1, output logic a2);
        cyc = 1'b1; stb = 1'b1; we = w;
        addr = 32'(off) << 2; wdata = d; sel = s;
        @(posedge clk); #1;
        a1 = ack; rd = rdata;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wdata = '0;
        @(posedge clk); #1;
        a2 = ack;
    endtask

    task automatic wb_write(input int off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; logic a1, a2;
        wb_access(1'b1, off, d, s, rd, a1, a2);
    endtask

    task automatic wb_read(input int off, output logic [31:0] rd);
        logic a1, a2;
        wb_access(1'b0, off, 32'h0, 4'hF, rd, a1, a2);
    endtask

    task automatic do_reset();
        cyc = 0; stb = 0; we = 0; addr = 0; wdata = 0; sel = 0;
        src = '0; eoi = '0;
        in_rst = 1'b0;
        step(2);
        in_rst = 1'b1;
        step(1);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] rd; logic a1, a2;
        do_reset();
        checks++;
        if (irq !== 32'h0 || ack !== 1'b0 || rdata !== 32'h0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs irq=%h ack=%b data=%h stall=%b required 0/0/0/0",
                     irq, ack, rdata, stall);
        end
        for (int off = 0; off < 8; off++) begin
            wb_access(1'b0, off, 32'h0, 4'hF, rd, a1, a2);
            checks++;
            if (a1 !== 1'b1 || a2 !== 1'b0 || rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_read off=%0d ack=%b,%b data=%h required 1,0 00000000",
                         off, a1, a2, rd);
            end
            $display("reset read off=%0d data=%h", off, rd);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_edge_eoi();
        logic [31:0] rd, exp;
        do_reset();
        wb_write(2, 32'h01, 4'hF);
        wb_write(1, 32'h01, 4'hF);
        src[0] = 1'b1;
        for (int i = 0; i <= SYNC + 1; i++) begin
            step(1);
            exp = (i == SYNC + 1) ? 32'h8 : 32'h0;
            checks++;
            if (irq !== exp) begin
                errors++;
                $display("FAIL edge_latency edge=E+%0d irq=%h required %h", i, irq, exp);
            end
        end
        step(1);
        src[0] = 1'b0;
        wb_read(0, rd);
        checks++;
        if (rd !== 32'h01) begin
            errors++;
            $display("FAIL edge_pending got=%h required 00000001", rd);
        end
        eoi[3] = 1'b1;
        step(1);
        eoi[3] = 1'b0;
        step(1);
        checks++;
        if (irq !== 32'h8) begin
            errors++;
            $display("FAIL eoi_irq_hold got=%h required 00000008", irq);
        end
        step(1);
        checks++;
        if (irq !== 32'h0) begin
            errors++;
            $display("FAIL eoi_irq_drop got=%h required 00000000", irq);
        end
        wb_read(0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL eoi_pending got=%h required 00000000", rd);
        end
        $display("edge/eoi scenario pending_after_eoi=%h", rd);
    endtask

    // ------------------------------------------------------------------
    task automatic test_level();
        logic [31:0] rd, exp;
        do_reset();
        wb_write(2, 32'h00, 4'hF);
        wb_write(1, 32'h80, 4'hF);
        src[7] = 1'b1;
        step(4);
        checks++;
        if (irq !== 32'h400) begin
            errors++;
            $display("FAIL level_irq got=%h required 00000400", irq);
        end
        wb_write(0, 32'h80, 4'hF);
        wb_read(0, rd);
        checks++;
        if (rd !== 32'h80 || irq !== 32'h400) begin
            errors++;
            $display("FAIL level_w1c pending=%h irq=%h required 00000080 00000400", rd, irq);
        end
        src[7] = 1'b0;
        for (int i = 0; i <= SYNC + 1; i++) begin
            step(1);
            exp = (i == SYNC + 1) ? 32'h0 : 32'h400;
            checks++;
            if (irq !== exp) begin
                errors++;
                $display("FAIL level_drop edge=E+%0d irq=%h required %h", i, irq, exp);
            end
        end
        $display("level scenario done irq=%h", irq);
    endtask

    // ------------------------------------------------------------------
    task automatic test_w1c_race();
        logic [31:0] rd;
        do_reset();
        wb_write(2, 32'h04, 4'hF);
        wb_write(1, 32'h04, 4'hF);
        wb_write(4, 32'h04, 4'hF);
        src[2] = 1'b1;
        // Capture edge, then one more so the W1C is sampled on the rise cycle
        step(SYNC);
        wb_write(0, 32'h04, 4'hF);
        wb_read(0, rd);
        checks++;
        if (rd !== 32'h04) begin
            errors++;
            $display("FAIL w1c_race pending=%h required 00000004", rd);
        end
        wb_write(0, 32'h04, 4'hF);
        wb_read(0, rd);
        checks++;
        if (rd !== 32'h00) begin
            errors++;
            $display("FAIL w1c_plain pending=%h required 00000000", rd);
        end
        $display("w1c race scenario pending=%h", rd);
    endtask

    // ------------------------------------------------------------------
    task automatic test_force();
        logic [31:0] rd;
        do_reset();
        wb_write(2, 32'h0F, 4'hF);
        wb_write(1, 32'hFF, 4'hF);
        wb_write(4, 32'hFF, 4'hF);
        wb_read(0, rd);
        checks++;
        if (rd !== 32'h0F) begin
            errors++;
            $display("FAIL force_pending got=%h required 0000000f", rd);
        end
        wb_read(3, rd);
        checks++;
        if (rd !== 32'h0F) begin
            errors++;
            $display("FAIL force_status got=%h required 0000000f", rd);
        end
        wb_read(4, rd);
        checks++;
        if (rd !== 32'h0 || irq !== 32'h78) begin
            errors++;
            $display("FAIL force_readback data=%h irq=%h required 00000000 00000078", rd, irq);
        end
        $display("force scenario irq=%h", irq);
    endtask

    // ------------------------------------------------------------------
    task automatic test_sel_reserved();
        logic [31:0] rd; logic a1, a2;
        do_reset();
        wb_write(1, 32'hFFFF_FFFF, 4'b0001);
        wb_read(1, rd);
        checks++;
        if (rd !== 32'hFF) begin
            errors++;
            $display("FAIL sel_enable got=%h required 000000ff", rd);
        end
        wb_write(1, 32'h0, 4'b1110);
        wb_write(2, 32'hA5, 4'hF);
        wb_access(1'b1, 6, 32'hFFFF_FFFF, 4'hF, rd, a1, a2);
        checks++;
        if (a1 !== 1'b1 || a2 !== 1'b0) begin
            errors++;
            $display("FAIL reserved_ack ack=%b,%b required 1,0", a1, a2);
        end
        wb_read(1, rd);
        checks++;
        if (rd !== 32'hFF) begin
            errors++;
            $display("FAIL sel_masked_enable got=%h required 000000ff", rd);
        end
        wb_read(2, rd);
        checks++;
        if (rd !== 32'hA5) begin
            errors++;
            $display("FAIL mode_readback got=%h required 000000a5", rd);
        end
        wb_read(6, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reserved_read got=%h required 00000000", rd);
        end
        $display("sel/reserved scenario enable=ff mode=%h", 8'hA5);
    endtask

    // ------------------------------------------------------------------
    task automatic test_mode_switch();
        logic [31:0] rd;
        do_reset();
        src[1] = 1'b1;
        step(4);
        wb_read(0, rd);
        checks++;
        if (rd !== 32'h02) begin
            errors++;
            $display("FAIL mode_level_pending got=%h required 00000002", rd);
        end
        wb_write(2, 32'h02, 4'hF);
        wb_read(0, rd);
        checks++;
        if (rd !== 32'h00) begin
            errors++;
            $display("FAIL mode_switch_clear got=%h required 00000000", rd);
        end
        $display("mode switch scenario pending=%h", rd);
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [31:0] d3;
        logic        a1, a2, a3, a4;
        do_reset();
        cyc = 1; stb = 1; sel = 4'hF;
        we = 1; addr = 32'h4; wdata = 32'h3C;
        @(posedge clk); #1; a1 = ack;
        we = 1; addr = 32'h8; wdata = 32'h11;
        @(posedge clk); #1; a2 = ack;
        we = 0; addr = 32'h4; wdata = 32'h0;
        @(posedge clk); #1; a3 = ack; d3 = rdata;
        cyc = 0; stb = 0;
        @(posedge clk); #1; a4 = ack;
        checks++;
        if ({a1, a2, a3, a4} !== 4'b1110) begin
            errors++;
            $display("FAIL b2b_ack got=%b required 1110", {a1, a2, a3, a4});
        end
        checks++;
        if (d3 !== 32'h3C) begin
            errors++;
            $display("FAIL b2b_read got=%h required 0000003c", d3);
        end
        $display("back-to-back acks=%b read=%h", {a1, a2, a3, a4}, d3);
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        do_reset();
        cyc = 1; stb = 1; we = 0; addr = 32'h4; sel = 4'hF;
        @(posedge clk); #1;
        cyc = 0; stb = 0;
        #1 in_rst = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ack got=%b required 0", ack);
        end
        in_rst = 1'b1;
        step(1);
        $display("async reset scenario ack=%b", ack);
    endtask

    // ------------------------------------------------------------------
    // Reference model: level bits equal the (settled) source; edge bits
    // accumulate 0->1 transitions, W1C/EOI clear them, FORCE sets them.
    task automatic test_random();
        logic [7:0]  m, en, s, s2, e, f, pend;
        logic [31:0] rd, exp_irq;
        do_reset();
        for (int it = 0; it < 20; it++) begin
            m  = 8'($urandom);
            en = 8'($urandom);
            src = '0;
            step(4);
            wb_write(2, {24'h0, m}, 4'hF);
            wb_write(1, {24'h0, en}, 4'hF);
            wb_write(0, 32'hFF, 4'hF);
            pend = 8'h00;

            s = 8'($urandom);
            src = s;
            step(4);
            pend = s;
            wb_read(0, rd);
            checks++;
            if (rd !== {24'h0, pend}) begin
                errors++;
                $display("FAIL rand_src1 it=%0d pending=%h required %h", it, rd, pend);
            end

            s2 = 8'($urandom);
            src = s2;
            step(4);
            pend = (s2 & ~m) | ((pend | (s2 & ~s)) & m);
            wb_read(3, rd);
            checks++;
            if (rd !== {24'h0, pend & en}) begin
                errors++;
                $display("FAIL rand_status it=%0d status=%h required %h", it, rd, pend & en);
            end

            e = 8'($urandom);
            eoi = ($urandom & ~(32'hFF << IRQ_BASE)) | (32'(e) << IRQ_BASE);
            step(1);
            eoi = '0;
            step(1);
            pend = (pend & ~m) | (pend & m & ~e);

            f = 8'($urandom);
            wb_write(4, {24'h0, f}, 4'hF);
            pend = pend | (f & m);
            wb_read(0, rd);
            checks++;
            if (rd !== {24'h0, pend}) begin
                errors++;
                $display("FAIL rand_eoi_force it=%0d pending=%h required %h", it, rd, pend);
            end
            exp_irq = 32'(pend & en) << IRQ_BASE;
            checks++;
            if (irq !== exp_irq) begin
                errors++;
                $display("FAIL rand_irq it=%0d irq=%h required %h", it, irq, exp_irq);
            end
            $display("random it=%0d mode=%h en=%h src=%h->%h eoi=%h force=%h pending=%h",
                     it, m, en, s, s2, e, f, pend);
        end
    endtask

    initial begin
        test_reset();
        test_edge_eoi();
        test_level();
        test_w1c_race();
        test_force();
        test_sel_reserved();
        test_mode_switch();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
